btn_op_capture: RTL

Receiving end of the operator-button interface. Synchronizes and debounces `BTN[3:0]`, detects press edges and decodes the one-hot button into the 2-bit ALU operation code (0001→AND 00, 0010→OR 01, 0100→ADD 10, 1000→SUB 11). It accepts a press only while the control FSM opens the selection window (S_Display with origin S_LFSRB), then holds `op_lat`/`op_valid` until the FSM consumes it on entry to S_ALU. Sits between the board buttons and `uC` in `Top`, in the `clk_10Mhz` domain.

---
 rtl/fsm_pkg.sv | 46 ++++
 rtl/debounce_bit.sv | 47 ++++
 rtl/btn_op_capture.sv | 92 +++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the control FSM, operator-button capture and ALU op encoding.
package fsm_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ARMED,
    CAP_HELD
  } cap_state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int unsigned NumBtn = 4;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NumBtn-1:0] v);
    return (v != '0) && ((v & (v - NumBtn'(1))) == '0);
  endfunction

  // Only meaningful for one-hot inputs; callers qualify with is_onehot().
  function automatic logic [1:0] btn2op(input logic [NumBtn-1:0] btn);
    logic [1:0] op;
    case (btn)
      4'b0001: op = OP_AND;
      4'b0010: op = OP_OR;
      4'b0100: op = OP_ADD;
      4'b1000: op = OP_SUB;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [NumBtn-1:0] op2btn(input logic [1:0] op);
    logic [NumBtn-1:0] btn;
    unique case (op)
      OP_AND:  btn = 4'b0001;
      OP_OR:   btn = 4'b0010;
      OP_ADD:  btn = 4'b0100;
      default: btn = 4'b1000;
    endcase
    return btn;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-button 2-FF synchronizer followed by a stability counter that commits the
// synchronized level once it has differed from the debounced level for DB cycles.
module debounce_bit #(
  parameter int unsigned DB = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int unsigned CntW = $clog2(DB) + 1;

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntW'(DB - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/btn_op_capture.sv
// Operator-button receiver: debounces BTN, detects press edges, decodes the one-hot
// press into an ALU op and holds it until the control FSM consumes it.
module btn_op_capture
  import fsm_pkg::*;
#(
  parameter bit          Simulacion = 1'b0,
  parameter int unsigned DB_HW      = 100_000,
  parameter int unsigned DB_SIM     = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NumBtn-1:0] btn_i,
  input  logic              ventana_i,
  input  logic              consumir_i,
  output logic [NumBtn-1:0] btn_db_o,
  output logic [1:0]        op_lat_o,
  output logic              op_valid_o,
  output logic              err_multi_o
);

  localparam int unsigned Db = Simulacion ? DB_SIM : DB_HW;

  logic [NumBtn-1:0] btn_db;
  logic [NumBtn-1:0] btn_db_prev_q;
  logic [NumBtn-1:0] rise;
  logic              press_single, press_multi;

  cap_state_t state_q, state_d;
  logic [1:0] op_lat_q, op_lat_d;
  logic       err_multi_q, err_multi_d;

  for (genvar i = 0; i < NumBtn; i++) begin : g_db
    debounce_bit #(
      .DB(Db)
    ) u_debounce_bit (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn_i   (btn_i[i]),
      .btn_db_o(btn_db[i])
    );
  end

  // Only presses matter; releases produce no event.
  assign rise         = btn_db & ~btn_db_prev_q;
  assign press_single = is_onehot(rise);
  assign press_multi  = (rise != '0) && !press_single;

  always_comb begin
    state_d     = state_q;
    op_lat_d    = op_lat_q;
    err_multi_d = 1'b0;
    unique case (state_q)
      CAP_IDLE: begin
        if (ventana_i) state_d = CAP_ARMED;
      end
      CAP_ARMED: begin
        // A capture beats a window closing on the same edge.
        if (press_single) begin
          op_lat_d = btn2op(rise);
          state_d  = CAP_HELD;
        end else begin
          err_multi_d = press_multi;
          if (!ventana_i) state_d = CAP_IDLE;
        end
      end
      CAP_HELD: begin
        if (consumir_i) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= CAP_IDLE;
      op_lat_q      <= OP_AND;
      err_multi_q   <= 1'b0;
      btn_db_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      op_lat_q      <= op_lat_d;
      err_multi_q   <= err_multi_d;
      btn_db_prev_q <= btn_db;
    end
  end

  assign btn_db_o    = btn_db;
  assign op_lat_o    = op_lat_q;
  assign op_valid_o  = (state_q == CAP_HELD);
  assign err_multi_o = err_multi_q;

endmodule
